// File: rtl/dynamic_branch_flush_ctrl_pkg.sv
// Shared types for the dynamic branch flush controller.
//   bht_ctr_t     : 2-bit saturating branch history counter
//   BHT_INIT      : reset value of every history counter (weakly not-taken)
//   flush_state_t : flush FSM states
//   bht_next      : saturating counter update helper
package dynamic_branch_flush_ctrl_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_INIT = 2'b01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        POST  = 2'd2
    } flush_state_t;

    // Move a history counter one step toward the actual outcome, saturating
    // at 2'b00 and 2'b11 so it never wraps.
    function automatic bht_ctr_t bht_next(bht_ctr_t cur, logic taken);
        bht_ctr_t nxt;
        nxt = cur;
        if (taken && cur != 2'b11) begin
            nxt = cur + 2'b01;
        end else if (!taken && cur != 2'b00) begin
            nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dynamic_branch_flush_ctrl_if.sv
// Signal bundle between the MEM-stage branch resolution / fetch logic and the
// flush controller.
//   master : pipeline side (drives stall, fetch_pc, resolution, ctrl_in)
//   slave  : flush controller (drives prediction, gated controls, redirect,
//            flushed, forwarding_mask, perf counter, debug state)
//
// Handshake: resolve_valid and uncond_redirect are single-cycle qualifiers
// with no ready; a resolution is taken when its qualifier is high, stall is
// low and the controller is not squashing (state IDLE or POST). Anything
// presented while stalled must be held by the pipeline until stall drops.
interface dynamic_branch_flush_ctrl_if
    import dynamic_branch_flush_ctrl_pkg::*;
#(
    parameter int CTRL_W = 7
) ();
    logic              stall;
    logic [15:0]       fetch_pc;
    logic              predict_taken;
    logic              resolve_valid;
    logic [15:0]       resolve_pc;
    logic              resolve_taken;
    logic              resolve_predicted;
    logic              uncond_redirect;
    logic [CTRL_W-1:0] ctrl_in;
    logic [CTRL_W-1:0] ctrl_out;
    logic              redirect;
    logic              flushed;
    logic [1:0]        forwarding_mask;
    logic [15:0]       mispredict_count;
    flush_state_t      dbg_state;
    logic [2:0]        dbg_cnt;

    modport master (
        output stall, fetch_pc, resolve_valid, resolve_pc, resolve_taken,
               resolve_predicted, uncond_redirect, ctrl_in,
        input  predict_taken, ctrl_out, redirect, flushed, forwarding_mask,
               mispredict_count, dbg_state, dbg_cnt
    );

    modport slave (
        input  stall, fetch_pc, resolve_valid, resolve_pc, resolve_taken,
               resolve_predicted, uncond_redirect, ctrl_in,
        output predict_taken, ctrl_out, redirect, flushed, forwarding_mask,
               mispredict_count, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/dynamic_branch_flush_ctrl_branch_history_table.sv
// Branch history table: 2^INDEX_BITS two-bit saturating counters.
//   clk, reset : clock, synchronous active-high reset (all entries -> BHT_INIT)
//   rd_idx     : combinational read index; rd_taken = counter MSB
//   wr_en      : update strobe; wr_idx entry steps toward wr_taken
// A read and write of the same index in one cycle returns the old value.
module branch_history_table
    import dynamic_branch_flush_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_taken,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);
    localparam int ENTRIES = 1 << INDEX_BITS;

    bht_ctr_t table_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= BHT_INIT;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= bht_next(table_q[wr_idx], wr_taken);
        end
    end

    assign rd_taken = table_q[rd_idx][1];

endmodule

// File: rtl/dynamic_branch_flush_ctrl.sv
// Dynamic branch flush controller.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of dynamic_branch_flush_ctrl_if (fetch lookup,
//                branch resolution, gated controls, redirect, flush status,
//                forwarding mask, mispredict counter, debug state/count)
// A flush starts on a mispredict or unconditional redirect seen in IDLE or
// POST, squashes ctrl_in for FLUSH_STAGES non-stalled cycles, then spends at
// least one POST cycle with reduced forwarding before returning to IDLE.
module dynamic_branch_flush_ctrl
    import dynamic_branch_flush_ctrl_pkg::*;
#(
    parameter int FLUSH_STAGES   = 3,
    parameter int BHT_INDEX_BITS = 4,
    parameter int CTRL_W         = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    dynamic_branch_flush_ctrl_if.slave bus
);
    localparam logic [2:0] FLUSH_CNT = 3'(FLUSH_STAGES);

    flush_state_t      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [15:0]       mcount_q;
    logic              mispredict;
    logic              accept;
    logic              flush_req;
    logic              flushing;
    logic [1:0]        fwd_mask;
    logic [CTRL_W-1:0] ctrl_gated;

    assign mispredict = bus.resolve_valid & (bus.resolve_taken != bus.resolve_predicted);
    // Resolutions arriving during FLUSH belong to squashed instructions.
    assign accept     = !reset && !bus.stall && (state_q != FLUSH);
    assign flush_req  = accept && (mispredict || bus.uncond_redirect);

    branch_history_table #(
        .INDEX_BITS(BHT_INDEX_BITS)
    ) u_bht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (bus.fetch_pc[BHT_INDEX_BITS:1]),
        .rd_taken (bus.predict_taken),
        .wr_en    (bus.resolve_valid && accept),
        .wr_idx   (bus.resolve_pc[BHT_INDEX_BITS:1]),
        .wr_taken (bus.resolve_taken)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        flushing = 1'b0;
        fwd_mask = 2'b11;
        case (state_q)
            IDLE: begin
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_CNT;
                end
            end
            FLUSH: begin
                flushing = 1'b1;
                // Forwarding is cut only in the last squashed cycle.
                fwd_mask = (cnt_q == 3'd1) ? 2'b00 : 2'b11;
                if (!bus.stall) begin
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = POST;
                    end
                end
            end
            POST: begin
                fwd_mask = 2'b10;
                if (flush_req) begin
                    state_d = FLUSH;
                    cnt_d   = FLUSH_CNT;
                end else if (!bus.stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Reset releases the pipeline immediately, even mid-flush.
        if (reset) begin
            flushing = 1'b0;
            fwd_mask = 2'b11;
        end
    end

    // Only mispredicts count; an uncond-only flush leaves the counter alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcount_q <= 16'd0;
        end else if (flush_req && mispredict && mcount_q != 16'hFFFF) begin
            mcount_q <= mcount_q + 16'd1;
        end
    end

    assign ctrl_gated           = flushing ? '0 : bus.ctrl_in;
    assign bus.ctrl_out         = ctrl_gated;
    assign bus.flushed          = flushing;
    assign bus.forwarding_mask  = fwd_mask;
    assign bus.redirect         = flush_req;
    assign bus.mispredict_count = mcount_q;
    assign bus.dbg_state        = state_q;
    assign bus.dbg_cnt          = cnt_q;

    // PC bits outside the table index do not take part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[15:BHT_INDEX_BITS+1], bus.fetch_pc[0],
                              bus.resolve_pc[15:BHT_INDEX_BITS+1], bus.resolve_pc[0]};

endmodule
